multicore_system_shared_ram: RTL

- Parametrised on-chip shared memory serving NUM_PORTS Avalon-MM slave ports, one per Nios core or DMA master, from a single RAM array.
- Successor to the fixed 2-port, 4096x32 core ROM/RAM: width, depth and port count are parametrised.
- Adds round-robin arbitration with waitrequest, pipelined reads with readdatavalid, and selectable read latency.
- Sits between the core data masters and the system interconnect as a shared scratchpad / mailbox memory.

---
 rtl/multicore_system_shared_ram.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/multicore_system_shared_ram.sv
// Shared on-chip RAM behind NUM_PORTS Avalon-MM slave ports.
// One grant per cycle, round-robin. Reads are pipelined with READ_LATENCY 1 or 2.
// Optional per-byte even parity is enabled with `define MULTICORE_SHARED_RAM_PARITY_EN.
// Array contents are not initialised here; INIT_FILE names the preload image
// used by the memory back-end ("UNUSED" leaves the contents undefined).
module multicore_system_shared_ram #(
    parameter int unsigned NUM_PORTS    = 2,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ADDR_W       = 12,
    parameter int unsigned READ_LATENCY = 1,
    parameter string       INIT_FILE    = "UNUSED"
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          reset_req,
    input  logic [NUM_PORTS-1:0]          chipselect,
    input  logic [NUM_PORTS-1:0]          read,
    input  logic [NUM_PORTS-1:0]          write,
    input  logic [NUM_PORTS*ADDR_W-1:0]   address,
    input  logic [NUM_PORTS*DATA_W/8-1:0] byteenable,
    input  logic [NUM_PORTS*DATA_W-1:0]   writedata,
    output logic [NUM_PORTS*DATA_W-1:0]   readdata,
    output logic [NUM_PORTS-1:0]          readdatavalid,
    output logic [NUM_PORTS-1:0]          waitrequest,
    output logic                          parity_err
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    // Reject illegal configurations at elaboration
    if (NUM_PORTS < 1 || NUM_PORTS > 8) begin : g_bad_ports
        $error("NUM_PORTS must be 1..8");
    end
    if (DATA_W == 0 || (DATA_W % 8) != 0) begin : g_bad_width
        $error("DATA_W must be a non-zero multiple of 8");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("READ_LATENCY must be 1 or 2");
    end
    if (INIT_FILE == "") begin : g_bad_init
        $error("INIT_FILE must name a file or be UNUSED");
    end

    logic [DATA_W-1:0]         mem_q [DEPTH];
    logic [PW-1:0]             last_q;
    logic [NUM_PORTS-1:0]      req_c;
    logic [NUM_PORTS-1:0]      grant_c;
    logic                      gnt_v_c;
    logic [PW-1:0]             gnt_idx_c;
    logic [PW-1:0]             cand_c;
    logic [ADDR_W-1:0]         sel_addr_c;
    logic [NB-1:0]             sel_be_c;
    logic [DATA_W-1:0]         sel_wd_c;
    logic [DATA_W-1:0]         be_mask_c;
    logic [DATA_W-1:0]         rd_word_c;
    logic                      wr_en_c;
    logic                      rd_en_c;
    logic                      src_v_c;
    logic [PW-1:0]             src_p_c;
    logic [DATA_W-1:0]         src_d_c;
    logic [NUM_PORTS-1:0]      rdv_q;
    logic [NUM_PORTS*DATA_W-1:0] rdata_q;

    // Round-robin search starting after the last granted port; reset_req blocks all grants
    always_comb begin
        req_c     = chipselect & (read | write);
        gnt_v_c   = 1'b0;
        gnt_idx_c = '0;
        cand_c    = '0;
        grant_c   = '0;
        if (!reset_req) begin
            for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
                cand_c = PW'((32'(last_q) + k) % NUM_PORTS);
                if (!gnt_v_c && req_c[cand_c]) begin
                    gnt_v_c   = 1'b1;
                    gnt_idx_c = cand_c;
                end
            end
        end
        if (gnt_v_c) begin
            grant_c[gnt_idx_c] = 1'b1;
        end
    end

    assign waitrequest = req_c & ~grant_c;

    // Mux the granted port's request onto the single array port
    always_comb begin
        sel_addr_c = address[32'(gnt_idx_c)*ADDR_W +: ADDR_W];
        sel_be_c   = byteenable[32'(gnt_idx_c)*NB +: NB];
        sel_wd_c   = writedata[32'(gnt_idx_c)*DATA_W +: DATA_W];
        wr_en_c    = gnt_v_c & write[gnt_idx_c];
        rd_en_c    = gnt_v_c & read[gnt_idx_c] & ~write[gnt_idx_c];
        rd_word_c  = mem_q[sel_addr_c];
    end

    for (genvar b = 0; b < NB; b++) begin : g_lane
        assign be_mask_c[b*8 +: 8] = {8{sel_be_c[b]}};
    end

    // Byte-masked write; the array itself is never reset
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem_q[sel_addr_c] <= (rd_word_c & ~be_mask_c) | (sel_wd_c & be_mask_c);
        end
    end

    // Arbitration pointer, moved only by an actual grant
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= PW'(NUM_PORTS - 1);
        end else if (gnt_v_c) begin
            last_q <= gnt_idx_c;
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic              v1_q;
        logic [PW-1:0]     p1_q;
        logic [DATA_W-1:0] d1_q;

        // Extra read stage ahead of the per-port output registers
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                v1_q <= 1'b0;
                p1_q <= '0;
                d1_q <= '0;
            end else begin
                v1_q <= rd_en_c;
                if (rd_en_c) begin
                    p1_q <= gnt_idx_c;
                    d1_q <= rd_word_c;
                end
            end
        end

        assign src_v_c = v1_q;
        assign src_p_c = p1_q;
        assign src_d_c = d1_q;
    end else begin : g_lat1
        assign src_v_c = rd_en_c;
        assign src_p_c = gnt_idx_c;
        assign src_d_c = rd_word_c;
    end

    // Per-port output registers: valid pulses one cycle, data holds until the next read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdv_q   <= '0;
            rdata_q <= '0;
        end else begin
            rdv_q <= '0;
            if (src_v_c) begin
                rdv_q[src_p_c]                            <= 1'b1;
                rdata_q[32'(src_p_c)*DATA_W +: DATA_W]    <= src_d_c;
            end
        end
    end

    assign readdata      = rdata_q;
    assign readdatavalid = rdv_q;

`ifdef MULTICORE_SHARED_RAM_PARITY_EN
    logic [NB-1:0] par_mem_q [DEPTH];
    logic [NB-1:0] wr_par_c;
    logic [NB-1:0] rd_par_c;
    logic [NB-1:0] par_word_c;
    logic          perr_q;

    for (genvar b = 0; b < NB; b++) begin : g_par
        assign wr_par_c[b] = ^sel_wd_c[b*8 +: 8];
        assign rd_par_c[b] = ^rd_word_c[b*8 +: 8];
    end

    assign par_word_c = par_mem_q[sel_addr_c];

    // Parity bits follow the same byte enables as the data
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            par_mem_q[sel_addr_c] <= (par_word_c & ~sel_be_c) | (wr_par_c & sel_be_c);
        end
    end

    // Sticky error on any byte mismatch of a granted read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perr_q <= 1'b0;
        end else if (rd_en_c && (rd_par_c != par_word_c)) begin
            perr_q <= 1'b1;
        end
    end

    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule
